// File: rtl/uart_rx_frame.sv
// rtl/uart_rx_frame.sv - parametrised UART receiver with valid/ready frame delivery
// Optional feature macro: UART_RX_MAJORITY_VOTE_EN (2-of-3 majority sampling)

module uart_rx_frame #(
   parameter int CLK_RATE  = 100000000,
   parameter int BAUD_RATE = 115200,
   parameter int DATA_BITS = 8,
   parameter int PARITY    = 0,
   parameter int STOP_BITS = 1
) (
   input  logic                 Clk,
   input  logic                 Reset,
   input  logic                 Rx,
   output logic [DATA_BITS-1:0] RxData,
   output logic                 RxValid,
   input  logic                 RxReady,
   output logic                 RxParityErr,
   output logic                 RxFrameErr,
   output logic                 RxOverrun,
   output logic                 RxBusy
);

   localparam int CLKS_PER_BIT = CLK_RATE / BAUD_RATE;
   localparam int HALF_T       = CLKS_PER_BIT / 2 - 1;
   localparam int FULL_T       = CLKS_PER_BIT - 1;

`ifdef UART_RX_MAJORITY_VOTE_EN
   // The counter must reach target+1, and the post-decision count starts at 1
   // so consecutive sample points stay exactly one bit period apart.
   localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
   localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(1);
`else
   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] CNT_RELOAD = '0;
`endif

   if (CLKS_PER_BIT < 4 || DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
       STOP_BITS < 1 || STOP_BITS > 2) begin : gParamCheck
      $error("uart_rx_frame: illegal parameter set");
   end

   typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

   state_t               state, nextState;
   logic                 rxMeta, rxs, rxsPrev, armed;
   logic [1:0]           fill;
   logic [CNT_W-1:0]     cnt, targ;
   logic [3:0]           bitCnt;
   logic                 stopCnt;
   logic [DATA_BITS-1:0] shiftReg;
   logic                 parErr, frmErr;
   logic                 tick, sampleBit, startEdge, frameDone, lastData, lastStop;

   assign targ      = (state == START) ? CNT_W'(HALF_T) : CNT_W'(FULL_T);
   assign startEdge = armed & rxsPrev & ~rxs;
   assign lastData  = (bitCnt == 4'(DATA_BITS - 1));
   assign lastStop  = (stopCnt == 1'(STOP_BITS - 1));
   assign RxBusy    = (state != IDLE);

`ifdef UART_RX_MAJORITY_VOTE_EN
   logic [1:0] vote;

   // Capture the two early votes ahead of the decision point
   always_ff @(posedge Clk) begin
      if (!Reset) begin
         vote <= 2'b11;
      end else begin
         if (cnt == targ - CNT_W'(1)) vote[0] <= rxs;
         if (cnt == targ)             vote[1] <= rxs;
      end
   end

   assign sampleBit = (vote[0] & vote[1]) | (vote[0] & rxs) | (vote[1] & rxs);
   assign tick      = (state != IDLE) && (cnt == targ + CNT_W'(1));
`else
   assign sampleBit = rxs;
   assign tick      = (state != IDLE) && (cnt == targ);
`endif

   // Pin synchroniser; a start edge is only trusted once a real idle 1 has arrived
   always_ff @(posedge Clk) begin
      if (!Reset) begin
         rxMeta  <= 1'b1;
         rxs     <= 1'b1;
         rxsPrev <= 1'b1;
         fill    <= 2'b00;
         armed   <= 1'b0;
      end else begin
         rxMeta  <= Rx;
         rxs     <= rxMeta;
         rxsPrev <= rxs;
         fill    <= {fill[0], 1'b1};
         armed   <= armed | (fill[1] & rxs);
      end
   end

   // FSM state register
   always_ff @(posedge Clk) begin
      if (!Reset) state <= IDLE;
      else        state <= nextState;
   end

   // Next-state logic and frame completion strobe
   always_comb begin
      nextState = state;
      frameDone = 1'b0;
      case (state)
         IDLE:  if (startEdge) nextState = START;
         START: if (tick) nextState = sampleBit ? IDLE : DATA;
         DATA:  if (tick && lastData) nextState = (PARITY != 0) ? PAR : STOP;
         PAR:   if (tick) nextState = STOP;
         STOP:  if (tick && lastStop) begin
                   nextState = IDLE;
                   frameDone = 1'b1;
                end
         default: nextState = IDLE;
      endcase
   end

   // Bit timing counters, data shifter and per-frame error accumulation
   always_ff @(posedge Clk) begin
      if (!Reset) begin
         cnt      <= '0;
         bitCnt   <= '0;
         stopCnt  <= 1'b0;
         shiftReg <= '0;
         parErr   <= 1'b0;
         frmErr   <= 1'b0;
      end else if (state == IDLE) begin
         cnt     <= '0;
         bitCnt  <= '0;
         stopCnt <= 1'b0;
         parErr  <= 1'b0;
         frmErr  <= 1'b0;
      end else begin
         cnt <= tick ? CNT_RELOAD : cnt + CNT_W'(1);
         if (tick) begin
            case (state)
               DATA: begin
                  shiftReg <= {sampleBit, shiftReg[DATA_BITS-1:1]};
                  bitCnt   <= bitCnt + 4'd1;
               end
               PAR: begin
                  if (PARITY == 1) parErr <= ~(^shiftReg ^ sampleBit);
                  else             parErr <= ^shiftReg ^ sampleBit;
               end
               STOP: begin
                  stopCnt <= stopCnt + 1'b1;
                  if (!sampleBit) frmErr <= 1'b1;
               end
               default: ;
            endcase
         end
      end
   end

   // Output holding register with valid/ready handshake and overrun pulse
   always_ff @(posedge Clk) begin
      if (!Reset) begin
         RxData      <= '0;
         RxValid     <= 1'b0;
         RxParityErr <= 1'b0;
         RxFrameErr  <= 1'b0;
         RxOverrun   <= 1'b0;
      end else if (frameDone) begin
         RxData      <= shiftReg;
         RxParityErr <= parErr;
         RxFrameErr  <= frmErr | ~sampleBit;
         RxValid     <= 1'b1;
         RxOverrun   <= RxValid & ~RxReady;
      end else begin
         RxOverrun <= 1'b0;
         if (RxValid && RxReady) RxValid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_uart_rx_frame.sv
// tb/tb_uart_rx_frame.sv - scoreboard bench for uart_rx_frame (default, fast 8N1, fast 7E1)

module tb_uart_rx_frame;

   logic Clk = 1'b0;
   always #5 Clk = ~Clk;

   logic       Reset;
   logic       rxDef, rxFast, rxPar;
   logic       rdyDef, rdyFast, rdyPar;
   logic [7:0] dDef, dFast;
   logic [6:0] dPar;
   logic       vDef, peDef, feDef, ovDef, bzDef;
   logic       vFast, peFast, feFast, ovFast, bzFast;
   logic       vPar, pePar, fePar, ovPar, bzPar;

   uart_rx_frame uDef (
      .Clk(Clk), .Reset(Reset), .Rx(rxDef), .RxData(dDef), .RxValid(vDef), .RxReady(rdyDef),
      .RxParityErr(peDef), .RxFrameErr(feDef), .RxOverrun(ovDef), .RxBusy(bzDef));

   uart_rx_frame #(.CLK_RATE(1600), .BAUD_RATE(100)) uFast (
      .Clk(Clk), .Reset(Reset), .Rx(rxFast), .RxData(dFast), .RxValid(vFast), .RxReady(rdyFast),
      .RxParityErr(peFast), .RxFrameErr(feFast), .RxOverrun(ovFast), .RxBusy(bzFast));

   uart_rx_frame #(.CLK_RATE(1600), .BAUD_RATE(100), .DATA_BITS(7), .PARITY(2)) uPar (
      .Clk(Clk), .Reset(Reset), .Rx(rxPar), .RxData(dPar), .RxValid(vPar), .RxReady(rdyPar),
      .RxParityErr(pePar), .RxFrameErr(fePar), .RxOverrun(ovPar), .RxBusy(bzPar));

   typedef struct packed {
      logic [8:0] data;
      logic       perr;
      logic       ferr;
   } exp_t;

   exp_t qDef[$], qFast[$], qPar[$];
   int   nCmp = 0, nFail = 0;
   int   ovCntDef = 0, ovCntFast = 0, ovCntPar = 0;
   bit   hsDef = 0, hsFast = 0, hsPar = 0;

   function automatic exp_t mk(input logic [8:0] d, input logic pe, input logic fe);
      exp_t r;
      r.data = d;
      r.perr = pe;
      r.ferr = fe;
      return r;
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
      nCmp++;
      if (act !== req) begin
         nFail++;
         $display("FAIL %s: actual %0h, required %0h", nm, act, req);
      end
   endtask

   task automatic unexpected(input string nm, input logic [8:0] d);
      nCmp++;
      nFail++;
      $display("FAIL %s: actual frame data %0h, required no frame", nm, d);
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic drive_rx(input int which, input logic v);
      case (which)
         0: rxDef = v;
         1: rxFast = v;
         default: rxPar = v;
      endcase
   endtask

   task automatic send_frame(input int which, input logic [8:0] d, input int nbits,
                             input bit hasPar, input logic pbit, input logic stopVal,
                             input int cpb, input int idle);
      drive_rx(which, 1'b0);
      repeat (cpb) tick();
      for (int i = 0; i < nbits; i++) begin
         drive_rx(which, d[i]);
         repeat (cpb) tick();
      end
      if (hasPar) begin
         drive_rx(which, pbit);
         repeat (cpb) tick();
      end
      drive_rx(which, stopVal);
      repeat (cpb) tick();
      drive_rx(which, 1'b1);
      repeat (idle) tick();
   endtask

   // Pop and compare on every accepted frame; valid must drop right after acceptance
   always @(negedge Clk) begin
      exp_t e;
      if (hsDef)  check("def valid clears after accept", vDef, 0);
      if (hsFast) check("fast valid clears after accept", vFast, 0);
      if (hsPar)  check("par valid clears after accept", vPar, 0);
      hsDef  = 0;
      hsFast = 0;
      hsPar  = 0;
      if (vDef === 1'b1 && rdyDef === 1'b1) begin
         hsDef = 1;
         if (qDef.size() == 0) unexpected("def unexpected frame", {1'b0, dDef});
         else begin
            e = qDef.pop_front();
            check("def data", {1'b0, dDef}, e.data);
            check("def parity err", peDef, e.perr);
            check("def frame err", feDef, e.ferr);
         end
      end
      if (vFast === 1'b1 && rdyFast === 1'b1) begin
         hsFast = 1;
         if (qFast.size() == 0) unexpected("fast unexpected frame", {1'b0, dFast});
         else begin
            e = qFast.pop_front();
            check("fast data", {1'b0, dFast}, e.data);
            check("fast parity err", peFast, e.perr);
            check("fast frame err", feFast, e.ferr);
         end
      end
      if (vPar === 1'b1 && rdyPar === 1'b1) begin
         hsPar = 1;
         if (qPar.size() == 0) unexpected("par unexpected frame", {2'b0, dPar});
         else begin
            e = qPar.pop_front();
            check("par data", {2'b0, dPar}, e.data);
            check("par parity err", pePar, e.perr);
            check("par frame err", fePar, e.ferr);
         end
      end
      if (ovDef === 1'b1)  ovCntDef++;
      if (ovFast === 1'b1) ovCntFast++;
      if (ovPar === 1'b1)  ovCntPar++;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: actual time limit reached, required run to finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int nb, n, low;
      Reset = 1'b0;
      rxDef = 1'b1; rxFast = 1'b1; rxPar = 1'b1;
      rdyDef = 1'b1; rdyFast = 1'b1; rdyPar = 1'b1;
      repeat (3) tick();
      check("reset def valid", vDef, 0);
      check("reset def busy", bzDef, 0);
      check("reset def data", dDef, 0);
      check("reset def overrun", ovDef, 0);
      check("reset def errs", {peDef, feDef}, 0);
      check("reset fast valid/busy", {vFast, bzFast}, 0);
      check("reset par valid/busy", {vPar, bzPar}, 0);
      Reset = 1'b1;
      repeat (10) tick();

      // 0xA5 8N1 at 868 clocks per bit
      qDef.push_back(mk(9'h0A5, 1'b0, 1'b0));
      send_frame(0, 9'h0A5, 8, 0, 1'b0, 1'b1, 868, 100);

      // 200-cycle low glitch: false start, busy for ~434 cycles
      drive_rx(0, 1'b0);
      low = 0;
      n = 0;
      while (bzDef !== 1'b1 && n < 10) begin
         tick(); n++; low++;
      end
      check("def busy on false start", bzDef, 1);
      nb = 0;
      while (bzDef === 1'b1 && nb < 1000) begin
         tick(); nb++; low++;
         if (low == 200) drive_rx(0, 1'b1);
      end
      drive_rx(0, 1'b1);
      nCmp++;
      if (nb < 430 || nb > 440) begin
         nFail++;
         $display("FAIL def false-start busy length: actual %0d, required 430..440", nb);
      end
      repeat (50) tick();
      check("def no overrun", ovCntDef, 0);

      // 7E1 parity cases
      qPar.push_back(mk(9'h003, 1'b1, 1'b0));
      send_frame(2, 9'h003, 7, 1, 1'b1, 1'b1, 16, 32);
      qPar.push_back(mk(9'h003, 1'b0, 1'b0));
      send_frame(2, 9'h003, 7, 1, 1'b0, 1'b1, 16, 32);
      qPar.push_back(mk(9'h055, 1'b0, 1'b0));
      send_frame(2, 9'h055, 7, 1, 1'b0, 1'b1, 16, 32);
      qPar.push_back(mk(9'h07F, 1'b1, 1'b0));
      send_frame(2, 9'h07F, 7, 1, 1'b0, 1'b1, 16, 32);

      // Framing error then a clean frame
      qFast.push_back(mk(9'h03C, 1'b0, 1'b1));
      send_frame(1, 9'h03C, 8, 0, 1'b0, 1'b0, 16, 32);
      qFast.push_back(mk(9'h011, 1'b0, 1'b0));
      send_frame(1, 9'h011, 8, 0, 1'b0, 1'b1, 16, 32);

      // Overrun: two frames back to back with the consumer stalled
      rdyFast = 1'b0;
      send_frame(1, 9'h012, 8, 0, 1'b0, 1'b1, 16, 0);
      send_frame(1, 9'h034, 8, 0, 1'b0, 1'b1, 16, 16);
      check("fast overrun pulses", ovCntFast, 1);
      check("fast valid held", vFast, 1);
      check("fast data overwritten", dFast, 8'h34);
      qFast.push_back(mk(9'h034, 1'b0, 1'b0));
      rdyFast = 1'b1;
      repeat (5) tick();

      // Reset in the middle of 0xFF, then a clean 0x5A
      fork
         send_frame(1, 9'h0FF, 8, 0, 1'b0, 1'b1, 16, 32);
         begin
            repeat (88) tick();
            check("fast busy mid-frame", bzFast, 1);
            Reset = 1'b0;
            tick();
            Reset = 1'b1;
            @(negedge Clk);
            check("mid reset fast valid", vFast, 0);
            check("mid reset fast busy", bzFast, 0);
            check("mid reset fast data", dFast, 0);
            check("mid reset fast errs/overrun", {peFast, feFast, ovFast}, 0);
         end
      join
      qFast.push_back(mk(9'h05A, 1'b0, 1'b0));
      send_frame(1, 9'h05A, 8, 0, 1'b0, 1'b1, 16, 32);

      repeat (20) tick();
      check("def queue drained", qDef.size(), 0);
      check("fast queue drained", qFast.size(), 0);
      check("par queue drained", qPar.size(), 0);
      check("par no overrun", ovCntPar, 0);
      $display("== %0d vectors applied, %0d miscompares ==", nCmp, nFail);
      $finish;
   end

endmodule
